// File: rtl/register_file_pkg.sv
// Shared constants and the word type for the 8 x 32-bit register file.
package register_file_pkg;
   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 3;
   localparam int RF_DEPTH      = 8;

   typedef logic [RF_DATA_WIDTH-1:0] rf_word_t;
endpackage

// File: rtl/register_file_reg.sv
// One storage word: async active-low clear, loads i_d on a clock edge when i_load is high.
module register_file_reg
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);

   logic [DATA_WIDTH-1:0] r_q;

   // Word storage; clear takes effect immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// 8 x 32-bit register file: one synchronous write port, one combinational read port.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DEPTH      = RF_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wAddr,
   input  logic [DATA_WIDTH-1:0] wData,
   input  logic [ADDR_WIDTH-1:0] rAddr,
   output logic [DATA_WIDTH-1:0] rData
);

   logic [DEPTH-1:0]      w_load;
   logic [DATA_WIDTH-1:0] w_q [DEPTH];

   // Write-address decoder: one-hot load enable, all zero when we is low.
   always_comb begin
      w_load = '0;
      if (we) begin
         w_load[wAddr] = 1'b1;
      end else begin
         w_load = '0;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_regs
      register_file_reg #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_reg (
         .clk     (clk),
         .reset_n (reset_n),
         .i_load  (w_load[g]),
         .i_d     (wData),
         .o_q     (w_q[g])
      );
   end

   // Read multiplexer: follows stored contents directly, no bypass of wData.
   always_comb begin
      rData = w_q[rAddr];
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;

   logic        clk;
   logic        reset_n;
   logic        we;
   logic [2:0]  wAddr;
   logic [31:0] wData;
   logic [2:0]  rAddr;
   logic [31:0] rData;

   logic [31:0] model [8];
   int unsigned checks;
   int unsigned errors;

   register_file dut (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .wAddr   (wAddr),
      .wData   (wData),
      .rAddr   (rAddr),
      .rData   (rData)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model[i] = 32'h0000_0000;
   endtask

   // Drives one write at a falling edge, lets the rising edge take it, then updates the model.
   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wAddr = a; wData = d;
      @(posedge clk);
      model[a] = d;
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; we = 1'b1; wAddr = 3'd0; wData = 32'hDEAD_BEEF; rAddr = 3'd0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rAddr = i[2:0];
         #1;
         checks++;
         if (rData !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_read addr=%0d got=%h exp=%h", i, rData, 32'h0000_0000);
         end
      end
      @(negedge clk);
      we = 1'b0;
      #5 reset_n = 1'b1;
   endtask

   task automatic test_seq_writes();
      do_write(3'd0, 32'h1111_1111);
      do_write(3'd1, 32'hFF00_FF00);
      do_write(3'd2, 32'hFF00_FF00);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rAddr = i[2:0];
         #1;
         checks++;
         if (rData !== model[i]) begin
            errors++;
            $display("FAIL seq_write addr=%0d got=%h exp=%h", i, rData, model[i]);
         end
      end
   endtask

   task automatic test_we_gating();
      @(negedge clk);
      we = 1'b1; wAddr = 3'd3; wData = 32'h00FF_00FF; rAddr = 3'd3;
      #5 we = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL we_gating got=%h exp=%h", rData, 32'h0000_0000);
      end
      // Data changing between edges while we is high must not be captured early.
      @(negedge clk);
      we = 1'b1; wAddr = 3'd6; wData = 32'h1234_5678; rAddr = 3'd6;
      #3 wData = 32'hCAFE_F00D;
      @(posedge clk);
      model[6] = 32'hCAFE_F00D;
      #1;
      we = 1'b0;
      checks++;
      if (rData !== model[6]) begin
         errors++;
         $display("FAIL edge_sample got=%h exp=%h", rData, model[6]);
      end
   endtask

   task automatic test_untouched();
      @(negedge clk);
      rAddr = 3'd5;
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL untouched5 got=%h exp=%h", rData, 32'h0000_0000);
      end
      rAddr = 3'd7;
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL untouched7 got=%h exp=%h", rData, 32'h0000_0000);
      end
   endtask

   task automatic test_async_read();
      @(negedge clk);
      #3 rAddr = 3'd1;
      #1;
      checks++;
      if (rData !== 32'hFF00_FF00) begin
         errors++;
         $display("FAIL async_read1 got=%h exp=%h", rData, 32'hFF00_FF00);
      end
      rAddr = 3'd0;
      #1;
      checks++;
      if (rData !== 32'h1111_1111) begin
         errors++;
         $display("FAIL async_read0 got=%h exp=%h", rData, 32'h1111_1111);
      end
   endtask

   task automatic test_rdw_reset();
      @(negedge clk);
      rAddr = 3'd4; wAddr = 3'd4; wData = 32'hA5A5_A5A5; we = 1'b1;
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL rdw_before got=%h exp=%h", rData, 32'h0000_0000);
      end
      @(posedge clk);
      model[4] = 32'hA5A5_A5A5;
      #1;
      we = 1'b0;
      checks++;
      if (rData !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL rdw_after got=%h exp=%h", rData, 32'hA5A5_A5A5);
      end
      #3 reset_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL async_reset got=%h exp=%h", rData, 32'h0000_0000);
      end
      rAddr = 3'd0;
      #1;
      checks++;
      if (rData !== 32'h0000_0000) begin
         errors++;
         $display("FAIL async_reset0 got=%h exp=%h", rData, 32'h0000_0000);
      end
      #1 reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] exp_v;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         we    = ($urandom_range(0, 3) != 0);
         wAddr = 3'($urandom_range(0, 7));
         wData = $urandom;
         rAddr = (n % 4 == 0) ? wAddr : 3'($urandom_range(0, 7));
         #1;
         checks++;
         if (rData !== model[rAddr]) begin
            errors++;
            $display("FAIL rand_pre n=%0d addr=%0d got=%h exp=%h", n, rAddr, rData, model[rAddr]);
         end
         @(posedge clk);
         if (we) model[wAddr] = wData;
         #1;
         exp_v = model[rAddr];
         checks++;
         if (rData !== exp_v) begin
            errors++;
            $display("FAIL rand_post n=%0d addr=%0d got=%h exp=%h", n, rAddr, rData, exp_v);
         end
      end
      we = 1'b0;
      // Final sweep of every entry against the model.
      for (int i = 0; i < 8; i++) begin
         rAddr = i[2:0];
         #1;
         checks++;
         if (rData !== model[i]) begin
            errors++;
            $display("FAIL rand_sweep addr=%0d got=%h exp=%h", i, rData, model[i]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_seq_writes();
      test_we_gating();
      test_untouched();
      test_async_read();
      test_rdw_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
